countdown_timer_1hz: RTL and testbench



---
 rtl/countdown_pkg.sv | 22 ++
 rtl/tick_prescaler_1hz.sv | 31 +++
 rtl/countdown_timer_1hz.sv | 134 +++++++++++++
 tb/tb_countdown_timer_1hz.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// countdown_pkg -- shared state encoding, field limits and saturation helper for mm:ss timers.
// Rev 1.0
`default_nettype none

package countdown_pkg;
   localparam int FIELD_W = 6;
   localparam int MAX_VAL = 59;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic logic [FIELD_W-1:0] sat_field(input logic [FIELD_W-1:0] v,
                                                    input logic [FIELD_W-1:0] max_v);
      return (v > max_v) ? max_v : v;
   endfunction
endpackage

`default_nettype wire

// File: rtl/tick_prescaler_1hz.sv
// tick_prescaler_1hz -- modulo-DIV counter; tick is high during the cycle the count wraps.
// Rev 1.0
`default_nettype none

module tick_prescaler_1hz #(
   parameter int DIV = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic tick
);
   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable)
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
   end

   assign tick = enable && (cnt == LAST);
endmodule

`default_nettype wire

// File: rtl/countdown_timer_1hz.sv
// countdown_timer_1hz -- mm:ss down-counter with load/start/pause and terminal-count flag.
// Optional COUNTDOWN_AUTO_RELOAD_EN: reload preset at 00:00 and keep running. Rev 1.0
`default_nettype none

module countdown_timer_1hz import countdown_pkg::*; #(
   parameter int DIV     = 100_000_000,
   parameter int MAX_VAL = countdown_pkg::MAX_VAL
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               start,
   input  logic               pause,
   input  logic [FIELD_W-1:0] set_min,
   input  logic [FIELD_W-1:0] set_sec,
   output logic [FIELD_W-1:0] minutes,
   output logic [FIELD_W-1:0] sec_count,
   output logic               tick_1hz,
   output logic               running,
   output logic               done
);
   localparam logic [FIELD_W-1:0] MAX_F = FIELD_W'(MAX_VAL);

   state_t             state, state_nx;
   logic [FIELD_W-1:0] preset_min, preset_sec, preset_min_nx, preset_sec_nx;
   logic [FIELD_W-1:0] min_nx, sec_nx;
   logic               tick_nx, done_nx;
   logic               ps_enable, ps_clear, ps_tick;
   logic               count_zero;

   tick_prescaler_1hz #(.DIV(DIV)) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (ps_enable),
      .clear  (ps_clear),
      .tick   (ps_tick)
   );

   assign count_zero = (minutes == '0) && (sec_count == '0);

   always_comb begin
      state_nx      = state;
      min_nx        = minutes;
      sec_nx        = sec_count;
      preset_min_nx = preset_min;
      preset_sec_nx = preset_sec;
      tick_nx       = 1'b0;
      done_nx       = done;
      ps_enable     = 1'b0;
      ps_clear      = 1'b0;

      if (load && (state != RUN)) begin
         preset_min_nx = sat_field(set_min, MAX_F);
         preset_sec_nx = sat_field(set_sec, MAX_F);
         min_nx        = preset_min_nx;
         sec_nx        = preset_sec_nx;
         done_nx       = 1'b0;
         ps_clear      = 1'b1;
         state_nx      = IDLE;
      end else begin
         case (state)
            IDLE, PAUSED: begin
               if (start) begin
                  if (count_zero) begin
                     state_nx = DONE;
                     done_nx  = 1'b1;
                  end else begin
                     state_nx = RUN;
                     ps_clear = (state == IDLE);
                  end
               end
            end
            RUN: begin
               done_nx = 1'b0;
               if (pause) begin
                  state_nx = PAUSED;
               end else begin
                  ps_enable = 1'b1;
                  if (ps_tick) begin
                     tick_nx = 1'b1;
                     if (sec_count != '0) begin
                        sec_nx = sec_count - FIELD_W'(1);
                     end else begin
                        sec_nx = MAX_F;
                        min_nx = minutes - FIELD_W'(1);
                     end
                     if ((min_nx == '0) && (sec_nx == '0)) begin
                        done_nx = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if ((preset_min != '0) || (preset_sec != '0)) begin
                           min_nx = preset_min;
                           sec_nx = preset_sec;
                        end else begin
                           state_nx = DONE;
                        end
`else
                        state_nx = DONE;
`endif
                     end
                  end
               end
            end
            DONE: begin
               done_nx = 1'b1;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         minutes    <= '0;
         sec_count  <= '0;
         preset_min <= '0;
         preset_sec <= '0;
         tick_1hz   <= 1'b0;
         done       <= 1'b0;
         running    <= 1'b0;
      end else begin
         state      <= state_nx;
         minutes    <= min_nx;
         sec_count  <= sec_nx;
         preset_min <= preset_min_nx;
         preset_sec <= preset_sec_nx;
         tick_1hz   <= tick_nx;
         done       <= done_nx;
         running    <= (state_nx == RUN);
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_countdown_timer_1hz.sv
// tb_countdown_timer_1hz -- directed self-checking bench for countdown_timer_1hz with DIV=4.
// Rev 1.0
`default_nettype none

module tb_countdown_timer_1hz;
   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [5:0] set_min = '0;
   logic [5:0] set_sec = '0;
   logic [5:0] minutes, sec_count;
   logic       tick_1hz, running, done;

   int total = 0;
   int bad   = 0;

   countdown_timer_1hz #(.DIV(DIV), .MAX_VAL(59)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .start     (start),
      .pause     (pause),
      .set_min   (set_min),
      .set_sec   (set_sec),
      .minutes   (minutes),
      .sec_count (sec_count),
      .tick_1hz  (tick_1hz),
      .running   (running),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [5:0] m, input logic [5:0] s);
      set_min = m;
      set_sec = s;
      load    = 1'b1;
      step();
      load    = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      // reset state
      step(2);
      chk("rst_min", minutes, 0);
      chk("rst_sec", sec_count, 0);
      chk("rst_running", running, 0);
      chk("rst_tick", tick_1hz, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      step();

      // asynchronous reset mid-count at 01:30
      do_load(6'd1, 6'd30);
      chk("load_min", minutes, 1);
      chk("load_sec", sec_count, 30);
      do_start();
      step(2);
      chk("mid_running", running, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_min", minutes, 0);
      chk("async_sec", sec_count, 0);
      chk("async_running", running, 0);
      chk("async_done", done, 0);
      #2 rst_n = 1'b1;
      step(6);
      chk("post_rst_running", running, 0);
      chk("post_rst_tick", tick_1hz, 0);
      chk("post_rst_sec", sec_count, 0);

      // load 00:03 and run to terminal count
      do_load(6'd0, 6'd3);
      chk("l3_sec", sec_count, 3);
      do_start();
      chk("l3_running", running, 1);
      step(3);
      chk("l3_c3_tick", tick_1hz, 0);
      chk("l3_c3_sec", sec_count, 3);
      step();
      chk("l3_c4_tick", tick_1hz, 1);
      chk("l3_c4_sec", sec_count, 2);
      step();
      chk("l3_c5_tick", tick_1hz, 0);
      step(3);
      chk("l3_c8_tick", tick_1hz, 1);
      chk("l3_c8_sec", sec_count, 1);
      step(4);
      chk("l3_c12_tick", tick_1hz, 1);
      chk("l3_c12_done", done, 1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      chk("l3_c12_reload_sec", sec_count, 3);
      chk("l3_c12_running", running, 1);
      pause = 1'b1;
      step();
      pause = 1'b0;
`else
      chk("l3_c12_sec", sec_count, 0);
      chk("l3_c12_running", running, 0);
      step();
      chk("l3_c13_tick", tick_1hz, 0);
      chk("l3_c13_done", done, 1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("done_ignores_start", running, 0);
      chk("done_holds", done, 1);
`endif

      // minute borrow, then load ignored in RUN
      do_load(6'd1, 6'd0);
      chk("borrow_done_clr", done, 0);
      do_start();
      step(4);
      chk("borrow_tick", tick_1hz, 1);
      chk("borrow_min", minutes, 0);
      chk("borrow_sec", sec_count, 59);
      do_load(6'd5, 6'd5);
      chk("run_load_min", minutes, 0);
      chk("run_load_sec", sec_count, 59);
      chk("run_load_running", running, 1);
      pause = 1'b1;
      step();
      pause = 1'b0;
      chk("paused_running", running, 0);

      // pause/resume shifts the schedule by exactly 10 cycles
      do_load(6'd0, 6'd5);
      do_start();
      step(6);
      chk("pr_c6_sec", sec_count, 4);
      pause = 1'b1;
      step();
      pause = 1'b0;
      chk("pr_c7_running", running, 0);
      step(8);
      chk("pr_c15_sec", sec_count, 4);
      chk("pr_c15_tick", tick_1hz, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("pr_c16_running", running, 1);
      step();
      chk("pr_c17_tick", tick_1hz, 0);
      step();
      chk("pr_c18_tick", tick_1hz, 1);
      chk("pr_c18_sec", sec_count, 3);
      step(4);
      chk("pr_c22_tick", tick_1hz, 1);
      chk("pr_c22_sec", sec_count, 2);

      // pause+start: pause wins in RUN, start wins in PAUSED
      pause = 1'b1;
      start = 1'b1;
      step();
      chk("both_in_run", running, 0);
      step();
      chk("both_in_paused", running, 1);
      start = 1'b0;
      step();
      pause = 1'b0;

      // saturation and 00:00 start
      do_load(6'd63, 6'd60);
      chk("sat_min", minutes, 59);
      chk("sat_sec", sec_count, 59);
      do_load(6'd0, 6'd0);
      do_start();
      chk("zero_done", done, 1);
      chk("zero_running", running, 0);
      chk("zero_tick", tick_1hz, 0);
      step();
      chk("zero_tick_next", tick_1hz, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
      do_load(6'd0, 6'd2);
      chk("ar_done_clr", done, 0);
      do_start();
      step(4);
      chk("ar_c4_sec", sec_count, 1);
      step(4);
      chk("ar_c8_done", done, 1);
      chk("ar_c8_running", running, 1);
      chk("ar_c8_sec", sec_count, 2);
      chk("ar_c8_min", minutes, 0);
      step();
      chk("ar_c9_done", done, 0);
      step(7);
      chk("ar_c16_done", done, 1);
      chk("ar_c16_sec", sec_count, 2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
